c2w_point_xform: RTL

C2W_POINT_XFORM -- requirements
Module: c2w_point_xform

---
 rtl/c2w_point_xform.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/c2w_point_xform.sv
// c2w_point_xform: transforms a camera-space point into world space,
// out = M*p + t in signed Q12.4. A single shared multiplier steps through
// the nine products row by row. Each row is finished with the translation
// term, then floor-rounded and saturated back to 16 bits.
module c2w_point_xform #(
  parameter int INT_BITS   = 12,
  parameter int FRAC_BITS  = 4,
  parameter int TOTAL_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mat_load,
  input  logic [9*TOTAL_BITS-1:0] mat_in,
  input  logic [3*TOTAL_BITS-1:0] t_in,
  output logic                    busy,
  input  logic                    pt_valid,
  output logic                    pt_ready,
  input  logic [3*TOTAL_BITS-1:0] pt_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3*TOTAL_BITS-1:0] out_data,
  output logic [2:0]              out_sat
);

  localparam int PROD_W = 2 * TOTAL_BITS;
  // Headroom for three full-range products plus the scaled translation.
  localparam int ACC_W  = PROD_W + 4;
  localparam int SAT_W  = INT_BITS + FRAC_BITS;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SAT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [TOTAL_BITS-1:0]   ONE     = TOTAL_BITS'(1 << FRAC_BITS);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic signed [TOTAL_BITS-1:0] r_mat [3][3];
  logic signed [TOTAL_BITS-1:0] r_t   [3];
  logic signed [TOTAL_BITS-1:0] r_pt  [3];
  logic [1:0]                   r_row;
  logic [1:0]                   r_col;
  logic signed [ACC_W-1:0]      r_acc;
  logic [TOTAL_BITS-1:0]        r_out [3];
  logic [2:0]                   r_sat;
  logic                         r_outValid;

  logic                         w_accept;
  logic signed [TOTAL_BITS-1:0] w_mElem;
  logic signed [TOTAL_BITS-1:0] w_pElem;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACC_W-1:0]      w_base;
  logic signed [ACC_W-1:0]      w_sum;
  logic signed [ACC_W-1:0]      w_tScaled;
  logic signed [ACC_W-1:0]      w_withT;
  logic signed [ACC_W-1:0]      w_rounded;
  logic                         w_satHi;
  logic                         w_satLo;
  logic [TOTAL_BITS-1:0]        w_rowVal;

  // Handshake and status outputs; pt_ready is held low while reset is asserted.
  assign pt_ready  = (r_state == IDLE) && !rst;
  assign w_accept  = pt_valid && pt_ready;
  assign busy      = (r_state != IDLE);
  assign out_valid = r_outValid;
  assign out_sat   = r_sat;
  assign out_data  = {r_out[2], r_out[1], r_out[0]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: accept a point, run the nine products, then hold the result until it is taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nextState = MAC;
      MAC:  if (r_row == 2'd2 && r_col == 2'd2) w_nextState = OUT;
      OUT:  if (r_outValid && out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Matrix and translation registers; these load only while idle, so a coincident point already sees the new values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_mat[r][c] <= (r == c) ? ONE : '0;
        end
        r_t[r] <= '0;
      end
    end else if (r_state == IDLE && mat_load) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_mat[r][c] <= mat_in[TOTAL_BITS*(3*r+c) +: TOTAL_BITS];
        end
        r_t[r] <= t_in[TOTAL_BITS*r +: TOTAL_BITS];
      end
    end
  end

  // Point latch and row/column sequencing through the nine products in row-major order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_pt[i] <= '0;
      end
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_pt[i] <= pt_in[TOTAL_BITS*i +: TOTAL_BITS];
      end
      r_row <= '0;
      r_col <= '0;
    end else if (r_state == MAC) begin
      if (r_col == 2'd2) begin
        r_col <= '0;
        r_row <= (r_row == 2'd2) ? 2'd0 : r_row + 2'd1;
      end else begin
        r_col <= r_col + 2'd1;
      end
    end
  end

  // Shared multiplier, running sum, and row finishing: add t, floor-shift, saturate.
  always_comb begin
    w_mElem   = r_mat[r_row][r_col];
    w_pElem   = r_pt[r_col];
    w_prod    = PROD_W'(w_mElem) * PROD_W'(w_pElem);
    w_base    = (r_col == 2'd0) ? '0 : r_acc;
    w_sum     = w_base + ACC_W'(w_prod);
    w_tScaled = ACC_W'(r_t[r_row]) <<< FRAC_BITS;
    w_withT   = w_sum + w_tScaled;
    w_rounded = w_withT >>> FRAC_BITS;
    w_satHi   = (w_rounded > SAT_MAX);
    w_satLo   = (w_rounded < SAT_MIN);
    if (w_satHi) begin
      w_rowVal = SAT_MAX[TOTAL_BITS-1:0];
    end else if (w_satLo) begin
      w_rowVal = SAT_MIN[TOTAL_BITS-1:0];
    end else begin
      w_rowVal = w_rounded[TOTAL_BITS-1:0];
    end
  end

  // Accumulator and result registers; the result becomes valid when the last row is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_sat      <= '0;
      r_outValid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_out[i] <= '0;
      end
    end else if (r_state == MAC) begin
      if (r_col == 2'd2) begin
        r_out[r_row] <= w_rowVal;
        r_sat[r_row] <= w_satHi | w_satLo;
        r_acc        <= '0;
        if (r_row == 2'd2) begin
          r_outValid <= 1'b1;
        end
      end else begin
        r_acc <= w_sum;
      end
    end else if (r_state == OUT && r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule
